// File: rtl/servo_setpoint_ramp_if.sv
// ---------------------------------------------------------------------------
// servo_setpoint_ramp_if
//
// Purpose : Bundles the link between the setpoint ramp and the servo PWM
//           stage. The PWM stage announces each period start with frame_tick;
//           the ramp answers with the commanded width and its status flags.
//
// Signals :
//   frame_tick   PWM -> ramp   one-cycle pulse at each PWM period start
//   width        ramp -> PWM   commanded pulse width in clock cycles (W bits)
//   width_valid  ramp -> PWM   one-cycle pulse: width changed this cycle
//   at_target    ramp -> PWM   width currently equals the switch target
//
// Modports:
//   master  the setpoint ramp (drives width/status, samples frame_tick)
//   slave   the PWM stage     (drives frame_tick, samples width/status)
// ---------------------------------------------------------------------------
interface servo_setpoint_ramp_if #(
    parameter int W = 25
) ();

    logic         frame_tick;
    logic [W-1:0] width;
    logic         width_valid;
    logic         at_target;

    modport master (
        input  frame_tick,
        output width,
        output width_valid,
        output at_target
    );

    modport slave (
        output frame_tick,
        input  width,
        input  width_valid,
        input  at_target
    );

endinterface

// File: rtl/servo_setpoint_ramp.sv
// ---------------------------------------------------------------------------
// servo_setpoint_ramp
//
// Purpose : Command stage ahead of the servo PWM generator. The raw board
//           switches are synchronised and debounced, the accepted code is
//           mapped to a target pulse width (clamped to MAX_W), and the
//           commanded width is slewed toward that target by at most SLEW
//           per PWM frame.
//
// Ports   :
//   CLOCK_50   in   system clock, everything on the rising edge
//   RESET      in   asynchronous, active-high reset
//   SW         in   raw switch code, asynchronous to CLOCK_50
//   bus        master modport of servo_setpoint_ramp_if
//                   (frame_tick in; width, width_valid, at_target out)
//
// Behaviour summary:
//   - Each SW bit passes a two-flop synchroniser.
//   - A code is accepted once it has been seen unchanged for DEBOUNCE_CYC
//     consecutive compare cycles; any change restarts the window.
//   - target = min(MIN_W + code * SPAN_STEP, MAX_W).
//   - On every cycle with frame_tick high and width != target, width moves
//     toward target by min(|target - width|, SLEW); width_valid pulses for
//     the cycle in which the new width is first visible.
// ---------------------------------------------------------------------------
module servo_setpoint_ramp #(
    parameter int SW_BITS      = 3,
    parameter int W            = 25,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int MIN_W        = 25000,
    parameter int MAX_W        = 125000,
    parameter int SPAN_STEP    = 15000,
    parameter int SLEW         = 10000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic [SW_BITS-1:0]      SW,
    servo_setpoint_ramp_if.master   bus
);

    // Target arithmetic runs one bit wider than the width bus so that
    // MIN_W + code * SPAN_STEP cannot wrap before the clamp is applied.
    localparam int WX = W + 1;
    localparam logic [WX-1:0] MIN_W_X = WX'(MIN_W);
    localparam logic [WX-1:0] MAX_W_X = WX'(MAX_W);
    localparam logic [WX-1:0] SPAN_X  = WX'(SPAN_STEP);
    localparam logic [WX-1:0] SLEW_X  = WX'(SLEW);

    // Counter only needs to reach DEBOUNCE_CYC-1.
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    // -----------------------------------------------------------------------
    // Two-flop synchroniser, one independent chain per switch bit
    // -----------------------------------------------------------------------
    logic [SW_BITS-1:0] sw_sync;

    generate
        for (genvar gi = 0; gi < SW_BITS; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge CLOCK_50 or posedge RESET) begin
                if (RESET) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= SW[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sw_sync[gi] = sync_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Debounce: sw_cand trails sw_sync by one cycle, so a mismatch between
    // them means the synchronised code just moved and the window restarts.
    // The counter saturates at its last value; re-loading sw_stable with an
    // unchanged candidate while saturated is harmless.
    // -----------------------------------------------------------------------
    logic [SW_BITS-1:0] sw_cand_reg;
    logic [SW_BITS-1:0] sw_stable_reg;
    logic [CNT_W-1:0]   cnt_reg;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sw_cand_reg   <= '0;
            sw_stable_reg <= '0;
            cnt_reg       <= '0;
        end else begin
            sw_cand_reg <= sw_sync;
            if (sw_sync != sw_cand_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_LAST) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                sw_stable_reg <= sw_cand_reg;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Target width from the accepted code, clamped to the ceiling
    // -----------------------------------------------------------------------
    logic [WX-1:0] target_raw;
    logic [W-1:0]  target;

    assign target_raw = MIN_W_X + (WX'(sw_stable_reg) * SPAN_X);
    assign target     = (target_raw > MAX_W_X) ? MAX_W_X[W-1:0] : target_raw[W-1:0];

    // -----------------------------------------------------------------------
    // One slew step toward the target. Limiting the step to the remaining
    // distance is what prevents overshoot, including after a reversal.
    // -----------------------------------------------------------------------
    logic [W-1:0]          width_reg;
    logic signed [WX-1:0]  diff;
    logic [WX-1:0]         mag;
    logic [W-1:0]          step;
    logic [W-1:0]          width_stepped;

    always_comb begin
        diff          = $signed({1'b0, target}) - $signed({1'b0, width_reg});
        mag           = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        step          = (mag > SLEW_X) ? SLEW_X[W-1:0] : mag[W-1:0];
        width_stepped = diff[W] ? (width_reg - step) : (width_reg + step);
    end

    // -----------------------------------------------------------------------
    // Ramp FSM: IDLE while width sits on the target, RAMP while it is being
    // slewed. A tick in the first cycle after a target change already steps,
    // so the IDLE branch applies the step as well.
    // -----------------------------------------------------------------------
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t       state_reg;
    state_t       state_next;
    logic [W-1:0] width_next;
    logic         width_valid_reg;
    logic         width_valid_next;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg       <= IDLE;
            width_reg       <= MIN_W_X[W-1:0];
            width_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            width_reg       <= width_next;
            width_valid_reg <= width_valid_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        width_next       = width_reg;
        width_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (width_reg != target) begin
                    state_next = RAMP;
                    if (bus.frame_tick) begin
                        width_next       = width_stepped;
                        width_valid_next = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (width_reg == target) begin
                    state_next = IDLE;
                end else if (bus.frame_tick) begin
                    width_next       = width_stepped;
                    width_valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.width       = width_reg;
    assign bus.width_valid = width_valid_reg;
    assign bus.at_target   = (width_reg == target);

endmodule
